// File: rtl/mem_stream_unpack_if.sv
// Stream-side and memory-write-side signal bundle for mem_stream_unpack.
// master drives the merged stream; slave is the unpacker itself.
interface mem_stream_unpack_if #(
    parameter int NMEM = 12,
    parameter int DW   = 45,
    parameter int AW   = 6,
    parameter int BXW  = 3
);
    logic                 new_event;
    logic [DW-1:0]        stream_dat;
    logic                 stream_valid;
    logic                 wr_en;
    logic [3:0]           wr_sel;
    logic [BXW+AW-1:0]    wr_addr;
    logic [DW-1:0]        wr_dat;
    logic [NMEM*AW-1:0]   items_flat;
    logic                 busy;
    logic                 done;
    logic                 err;

    modport master (
        output new_event, stream_dat, stream_valid,
        input  wr_en, wr_sel, wr_addr, wr_dat, items_flat, busy, done, err
    );

    modport slave (
        input  new_event, stream_dat, stream_valid,
        output wr_en, wr_sel, wr_addr, wr_dat, items_flat, busy, done, err
    );
endinterface

// File: rtl/mem_stream_unpack.sv
// Splits the framed merged readout stream back into per-memory write strobes.
// Latency: one cycle from accepted data word to wr_*; no backpressure, gaps via stream_valid.
module mem_stream_unpack #(
    parameter int NMEM = 12,
    parameter int DW   = 45,
    parameter int AW   = 6,
    parameter int BXW  = 3
) (
    input  logic                  clk,
    input  logic                  reset_n,
    mem_stream_unpack_if.slave    bus
);
    typedef enum logic [2:0] {IDLE, HDR, DATA, SKIP, DONE} state_t;

    localparam logic [3:0] NMEM4   = 4'(NMEM);
    localparam logic [3:0] END_DST = 4'hF;
    localparam int         BX_LSB  = DW - BXW;
    localparam int         DST_LSB = BX_LSB - 4;
    localparam int         CNT_LSB = DST_LSB - AW;

    state_t                state_q, state_d;
    logic [3:0]            dest_q, dest_d;
    logic [BXW-1:0]        bx_q, bx_d;
    logic [AW-1:0]         rem_q, rem_d;
    logic [AW-1:0]         items_q [NMEM];
    logic [AW-1:0]         items_d [NMEM];
    logic [NMEM-1:0]       full_q, full_d;
    logic                  err_q, err_d;
    logic                  done_q, done_d;
    logic                  busy_q, busy_d;
    logic                  wr_en_q, wr_en_d;
    logic [3:0]            wr_sel_q, wr_sel_d;
    logic [BXW+AW-1:0]     wr_addr_q, wr_addr_d;
    logic [DW-1:0]         wr_dat_q, wr_dat_d;

    logic [BXW-1:0]        hdr_bx;
    logic [3:0]            hdr_dest;
    logic [AW-1:0]         hdr_cnt;

    assign hdr_bx   = bus.stream_dat[BX_LSB +: BXW];
    assign hdr_dest = bus.stream_dat[DST_LSB +: 4];
    assign hdr_cnt  = bus.stream_dat[CNT_LSB +: AW];

    always_comb begin
        state_d   = state_q;
        dest_d    = dest_q;
        bx_d      = bx_q;
        rem_d     = rem_q;
        items_d   = items_q;
        full_d    = full_q;
        err_d     = err_q;
        done_d    = done_q;
        busy_d    = busy_q;
        wr_en_d   = 1'b0;
        wr_sel_d  = wr_sel_q;
        wr_addr_d = wr_addr_q;
        wr_dat_d  = wr_dat_q;

        // new_event overrides everything, including a word presented in the same cycle
        if (bus.new_event) begin
            state_d = HDR;
            for (int k = 0; k < NMEM; k++) items_d[k] = '0;
            full_d  = '0;
            err_d   = 1'b0;
            done_d  = 1'b0;
            busy_d  = 1'b1;
        end else if (bus.stream_valid) begin
            case (state_q)
                HDR: begin
                    if (hdr_dest == END_DST) begin
                        state_d = DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else if (hdr_dest >= NMEM4) begin
                        err_d   = 1'b1;
                        rem_d   = hdr_cnt;
                        state_d = (hdr_cnt == '0) ? HDR : SKIP;
                    end else begin
                        dest_d  = hdr_dest;
                        bx_d    = hdr_bx;
                        rem_d   = hdr_cnt;
                        state_d = (hdr_cnt == '0) ? HDR : DATA;
                    end
                end
                DATA: begin
                    // once a memory has written its last address, further words are dropped
                    if (!full_q[dest_q]) begin
                        wr_en_d   = 1'b1;
                        wr_sel_d  = dest_q;
                        wr_addr_d = {bx_q, items_q[dest_q]};
                        wr_dat_d  = bus.stream_dat;
                        if (items_q[dest_q] == '1) begin
                            full_d[dest_q] = 1'b1;
                            err_d          = 1'b1;
                        end else begin
                            items_d[dest_q] = items_q[dest_q] + 1'b1;
                        end
                    end
                    rem_d = rem_q - 1'b1;
                    if (rem_q == AW'(1)) state_d = HDR;
                end
                SKIP: begin
                    rem_d = rem_q - 1'b1;
                    if (rem_q == AW'(1)) state_d = HDR;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            dest_q    <= '0;
            bx_q      <= '0;
            rem_q     <= '0;
            items_q   <= '{default: '0};
            full_q    <= '0;
            err_q     <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_sel_q  <= '0;
            wr_addr_q <= '0;
            wr_dat_q  <= '0;
        end else begin
            state_q   <= state_d;
            dest_q    <= dest_d;
            bx_q      <= bx_d;
            rem_q     <= rem_d;
            items_q   <= items_d;
            full_q    <= full_d;
            err_q     <= err_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
            wr_en_q   <= wr_en_d;
            wr_sel_q  <= wr_sel_d;
            wr_addr_q <= wr_addr_d;
            wr_dat_q  <= wr_dat_d;
        end
    end

    for (genvar k = 0; k < NMEM; k++) begin : g_items
        assign bus.items_flat[k*AW +: AW] = items_q[k];
    end

    assign bus.wr_en   = wr_en_q;
    assign bus.wr_sel  = wr_sel_q;
    assign bus.wr_addr = wr_addr_q;
    assign bus.wr_dat  = wr_dat_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.err     = err_q;
endmodule
